// File: rtl/kyber_mem_pkg.sv
// Shared definitions for the chunked wide-word memories: default chunk width,
// transfer FSM states and the chunk-count helper.
package kyber_mem_pkg;

    localparam int CHUNK_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    function automatic int chunk_count(input int data_width, input int chunk_width);
        return data_width / chunk_width;
    endfunction

endpackage

// File: rtl/chunk_dpram.sv
// True dual-port RAM, read-first on both ports, RD_LAT registered output stages.
// Port B is written after port A, so a same-address collision keeps port B data.
module chunk_dpram #(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  din_a,
    output logic [WIDTH-1:0]  dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  din_b,
    output logic [WIDTH-1:0]  dout_b
);

    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] pipe_a [RD_LAT];
    logic [WIDTH-1:0] pipe_b [RD_LAT];

    always_ff @(posedge clk) begin
        // reads sample mem before this edge's writes land (read-first)
        if (en_a) begin
            pipe_a[0] <= mem[addr_a];
        end
        if (en_b) begin
            pipe_b[0] <= mem[addr_b];
        end
        if (en_a && we_a) begin
            mem[addr_a] <= din_a;
        end
        if (en_b && we_b) begin
            mem[addr_b] <= din_b;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign dout_a = pipe_a[RD_LAT-1];
    assign dout_b = pipe_b[RD_LAT-1];

endmodule

// File: rtl/chunked_ram_streamer.sv
// Streams one wide word per transfer between a register interface and a chunk-wide
// dual-port RAM holding NUM_SLOTS words; port A stays a raw chunk port.
//
//  state | meaning
//  IDLE  | waiting for start; bad slot index pulses err
//  WRITE | one shadow chunk written to RAM per cycle, LSB chunk first
//  READ  | one address issued per cycle; chunks captured RD_LAT cycles later
//  DONE  | one-cycle done pulse, busy low
module chunked_ram_streamer
    import kyber_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 6400,
    parameter int CHUNK_WIDTH = CHUNK_WIDTH_DEF,
    parameter int NUM_SLOTS   = 4,
    parameter int RD_LAT      = 2,
    localparam int CHUNKS     = chunk_count(DATA_WIDTH, CHUNK_WIDTH),
    localparam int ADDR_W     = ((NUM_SLOTS * CHUNKS) > 1) ? $clog2(NUM_SLOTS * CHUNKS) : 1,
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   wr_mode,
    input  logic [SLOT_W-1:0]      slot,
    input  logic [DATA_WIDTH-1:0]  wide_din,
    output logic [DATA_WIDTH-1:0]  wide_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   ena_0,
    input  logic                   wea_0,
    input  logic [ADDR_W-1:0]      addra_0,
    input  logic [CHUNK_WIDTH-1:0] dina_0,
    output logic [CHUNK_WIDTH-1:0] douta_0
);

    localparam int CNT_W = $clog2(CHUNKS + 1);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
        $error("chunked_ram_streamer: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if ((RD_LAT < 1) || (RD_LAT > 2)) begin : g_bad_lat
        $error("chunked_ram_streamer: RD_LAT must be 1 or 2");
    end

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        left_q;
    logic [CNT_W-1:0]        cap_idx;
    logic [RD_LAT-1:0]       vld_pipe;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       base;
    logic [DATA_WIDTH-1:0]   shadow_q;
    logic [DATA_WIDTH-1:0]   asm_q;
    logic [DATA_WIDTH-1:0]   asm_nx;
    logic [CHUNK_WIDTH-1:0]  dout_b;
    logic                    slot_ok;
    logic                    accept;
    logic                    issuing;
    logic                    rd_issue;
    logic                    cap_vld;
    logic                    cap_last;
    logic                    en_b;
    logic                    we_b;

    assign slot_ok  = ({1'b0, slot} < (SLOT_W + 1)'(NUM_SLOTS));
    assign accept   = (state == IDLE) && start && slot_ok;
    assign base     = ADDR_W'(slot) * ADDR_W'(CHUNKS);
    assign issuing  = ((state == WRITE) || (state == READ)) && (left_q != '0);
    assign rd_issue = (state == READ) && (left_q != '0);
    assign cap_vld  = vld_pipe[RD_LAT-1];
    assign cap_last = cap_vld && (cap_idx == CNT_W'(CHUNKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        en_b     = 1'b0;
        we_b     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = wr_mode ? WRITE : READ;
                end
            end
            WRITE: begin
                busy = 1'b1;
                en_b = 1'b1;
                we_b = 1'b1;
                if (left_q == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            READ: begin
                busy = 1'b1;
                en_b = rd_issue;
                if (cap_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        asm_nx = asm_q;
        if (cap_vld && (cap_idx < CNT_W'(CHUNKS))) begin
            asm_nx[int'(cap_idx) * CHUNK_WIDTH +: CHUNK_WIDTH] = dout_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q    <= '0;
            cap_idx   <= '0;
            vld_pipe  <= '0;
            addr_q    <= '0;
            err       <= 1'b0;
            wide_dout <= '0;
        end else begin
            err      <= (state == IDLE) && start && !slot_ok;
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(rd_issue);
            if (accept) begin
                left_q  <= CNT_W'(CHUNKS);
                addr_q  <= base;
                cap_idx <= '0;
            end else if (issuing) begin
                left_q <= left_q - CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (cap_vld) begin
                cap_idx <= cap_idx + CNT_W'(1);
            end
            // merged buffer so the last chunk lands in wide_dout on the done edge
            if (cap_last) begin
                wide_dout <= asm_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr_mode) begin
            shadow_q <= wide_din;
        end else if ((state == WRITE) && issuing) begin
            shadow_q <= shadow_q >> CHUNK_WIDTH;
        end
        if (cap_vld) begin
            asm_q <= asm_nx;
        end
    end

    chunk_dpram #(
        .WIDTH  (CHUNK_WIDTH),
        .DEPTH  (NUM_SLOTS * CHUNKS),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk    (clk),
        .en_a   (ena_0),
        .we_a   (wea_0),
        .addr_a (addra_0),
        .din_a  (dina_0),
        .dout_a (douta_0),
        .en_b   (en_b),
        .we_b   (we_b),
        .addr_b (addr_q),
        .din_b  (shadow_q[CHUNK_WIDTH-1:0]),
        .dout_b (dout_b)
    );

endmodule
